// File: rtl/game_pkg.sv
// Shared encodings for the paddle/ball game sequencer:
// FSM state codes and board key indices.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        MISS      = 3'd3,
        GAME_OVER = 3'd4,
        WIN       = 3'd5
    } state_e;

    localparam int KEY_START  = 3;
    localparam int KEY_LAUNCH = 2;
    localparam int KEY_LEFT   = 1;
    localparam int KEY_RIGHT  = 0;

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchronizer for an active-low push-button,
// followed by a registered one-cycle press (falling-edge) pulse.
module key_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press_p
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic prev_q, prev_d;
    logic pulse_q, pulse_d;

    always_comb begin
        s1_d    = key_n;
        s2_d    = s1_q;
        prev_d  = s2_q;
        pulse_d = prev_q & ~s2_q;
    end

    // Released key reads as 1, so reset to 1 to avoid a false press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            prev_q  <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign press_p = pulse_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer: turns start/launch keys and ball events into the
// attract/serve/play/miss/game-over/win flow, tracking lives and score.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int          LIVES            = 3,
    parameter logic [24:0] MISS_PAUSE       = 25'd25_000_000,
    parameter int          POINTS_PER_BRICK = 10,
    parameter int          SCORE_W          = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         KEY,
    input  logic               ball_miss,
    input  logic               brick_hit,
    input  logic               bricks_cleared,
    output logic               lose,
    output logic               ball_hold,
    output logic               ball_launch,
    output logic               ball_reset,
    output logic [2:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         state_o,
    output logic               game_over,
    output logic               win
);

    localparam logic [2:0]       LIVES_INIT = 3'(LIVES);
    localparam logic [SCORE_W:0] PTS        = (SCORE_W+1)'(POINTS_PER_BRICK);

    logic start_p, launch_p;
    logic unused_keys;

    assign unused_keys = ^KEY[KEY_LEFT:KEY_RIGHT];

    key_sync_edge u_start (
        .clk     (clk),
        .rst     (rst),
        .key_n   (KEY[KEY_START]),
        .press_p (start_p)
    );

    key_sync_edge u_launch (
        .clk     (clk),
        .rst     (rst),
        .key_n   (KEY[KEY_LAUNCH]),
        .press_p (launch_p)
    );

    state_e             state_q, state_d;
    logic [2:0]         lives_q, lives_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [24:0]        cnt_q, cnt_d;
    logic               launch_q, launch_d;
    logic               reset_q, reset_d;
    logic [SCORE_W:0]   score_sum;

    assign score_sum = {1'b0, score_q} + PTS;

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        score_d = score_q;
        cnt_d   = cnt_q;

        // Brick points count even on the cycle that leaves PLAY.
        if (state_q == PLAY && brick_hit) begin
            score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        end

        unique case (state_q)
            IDLE, GAME_OVER, WIN: begin
                if (start_p) begin
                    state_d = SERVE;
                    lives_d = LIVES_INIT;
                    score_d = '0;
                end
            end
            SERVE: begin
                if (launch_p) state_d = PLAY;
            end
            PLAY: begin
                if (bricks_cleared) begin
                    state_d = WIN;
                end else if (ball_miss && lives_q == 3'd1) begin
                    state_d = GAME_OVER;
                    lives_d = 3'd0;
                end else if (ball_miss) begin
                    state_d = MISS;
                    lives_d = lives_q - 3'd1;
                    cnt_d   = MISS_PAUSE - 25'd1;
                end
            end
            MISS: begin
                if (cnt_q == 25'd0) state_d = SERVE;
                else                cnt_d   = cnt_q - 25'd1;
            end
            default: state_d = IDLE;
        endcase

        launch_d = (state_d == PLAY)  && (state_q != PLAY);
        reset_d  = (state_d == SERVE) && (state_q != SERVE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            lives_q  <= LIVES_INIT;
            score_q  <= '0;
            cnt_q    <= '0;
            launch_q <= 1'b0;
            reset_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            lives_q  <= lives_d;
            score_q  <= score_d;
            cnt_q    <= cnt_d;
            launch_q <= launch_d;
            reset_q  <= reset_d;
        end
    end

    // Paddle stays live in SERVE so the player can aim the serve.
    assign lose        = (state_q == IDLE) || (state_q == MISS) ||
                         (state_q == GAME_OVER) || (state_q == WIN);
    assign ball_hold   = (state_q == IDLE) || (state_q == SERVE) ||
                         (state_q == MISS);
    assign game_over   = (state_q == GAME_OVER);
    assign win         = (state_q == WIN);
    assign ball_launch = launch_q;
    assign ball_reset  = reset_q;
    assign lives       = lives_q;
    assign score       = score_q;
    assign state_o     = state_q;

endmodule
